gat_feat_streamer: RTL and testbench
====================================

GAT_FEAT_STREAMER -- requirements
Module: gat_feat_streamer

Interface
REQ-001 SHALL have parameter TOP_WIDTH, default 32, meaning bus width of the output stream data.
REQ-002 SHALL have parameter NEW_FEATURE_WIDTH, default 32, meaning width of one new-feature word read from the feature BRAM.
REQ-003 SHALL have parameter NUM_WORDS, default 43328, meaning number of feature words per readout (NUM_SUBGRAPHS*NUM_FEATURE_OUT, Cora); legal range is NUM_WORDS >= 1.
REQ-004 SHALL have parameter RD_LAT, default 2, meaning fixed feature-BRAM read latency in cycles (1..4).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, meaning skid FIFO entries; the legal minimum is RD_LAT+2.
REQ-006 SHALL have derived parameter NEW_FEATURE_ADDR_W = $clog2(NUM_WORDS).
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, a single-cycle readout request (driven from gat_ready rising edge).
REQ-010 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse after the last beat is accepted.
REQ-012 SHALL have port feat_bram_addrb, output, NEW_FEATURE_ADDR_W+2, the byte address driven to the GAT feature BRAM port B.
REQ-013 SHALL have port feat_bram_dout, input, NEW_FEATURE_WIDTH, the BRAM read data, valid RD_LAT cycles after its address.
REQ-014 SHALL have port m_tdata, output, TOP_WIDTH, the stream data, zero-extended from NEW_FEATURE_WIDTH.
REQ-015 SHALL have port m_tvalid, output, 1, the stream valid.
REQ-016 SHALL have port m_tready, input, 1, the stream ready.
REQ-017 SHALL have port m_tlast, output, 1, high on the beat carrying word NUM_WORDS-1.

Function
REQ-018 SHALL implement states IDLE, RUN (issuing reads), DRAIN (all reads issued, FIFO/pipe not empty) and DONE (single cycle, asserts done), then return to IDLE.
REQ-019 SHALL accept start only in IDLE; start in any other state is ignored with no side effect.
REQ-020 SHALL drive feat_bram_addrb = rd_idx << 2 (low two bits always 0), with rd_idx counting 0..NUM_WORDS-1 and no wrap.
REQ-021 SHALL issue a read in a RUN cycle only when fifo_count + inflight < FIFO_DEPTH (credit rule), so that FIFO overflow is impossible under any m_tready pattern.
REQ-022 SHALL track read issue through an RD_LAT-deep valid shift register and write feat_bram_dout into the FIFO when the register's tail is set.
REQ-023 SHALL drive m_tvalid high exactly when the FIFO is non-empty; m_tdata/m_tlast SHALL remain stable while m_tvalid is high and m_tready is low.
REQ-024 SHALL pop the FIFO on m_tvalid & m_tready; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-025 SHALL assert the first m_tvalid exactly RD_LAT+2 cycles after the start cycle; with m_tready held high, it SHALL sustain one beat per cycle with no bubbles.
REQ-026 SHALL transition RUN->DRAIN on the cycle the last address is issued and DRAIN->DONE when inflight==0, the FIFO is empty, and the tlast beat has been accepted.
REQ-027 SHALL, when NUM_WORDS==1, assert m_tlast on the single beat and follow the normal DONE path.
REQ-028 SHALL hold feat_bram_addrb at its last value when not issuing reads (no spurious address toggling requirement; data is ignored).

Reset
REQ-029 SHALL, on rst_n low (any state, including mid-readout), asynchronously force state IDLE, rd_idx 0, inflight 0, FIFO empty, busy 0, done 0, m_tvalid 0, m_tlast 0, m_tdata 0 and feat_bram_addrb 0; in-flight BRAM data SHALL be discarded.
REQ-030 SHALL accept a new start on the first clock edge after rst_n deasserts.

Structure
REQ-031 SHALL take state encoding (typedef) and the RD_LAT/FIFO_DEPTH defaults from the shared GAT package alongside the existing dataset defines.
REQ-032 SHALL instantiate one sub-module gat_feat_fifo (synchronous FIFO, first-word-fall-through, parameterised width and depth, with count output).

Verification
REQ-033 SHALL cover: NUM_WORDS=8, RD_LAT=2, BRAM model dout=index*3, m_tready=1, start at cycle 10 -> m_tvalid first at cycle 14, data 0,3,...,21 on consecutive cycles, m_tlast on 21, done one cycle after the beat is accepted.
REQ-034 SHALL cover: same, m_tready toggling 1,0,0,1 repeating -> identical data order, no loss or duplication, stable m_tdata while stalled, FIFO count never > 8.
REQ-035 SHALL cover: m_tready=0 for 50 cycles after start -> exactly FIFO_DEPTH reads issued, addrb stops at 0x1C, then the remainder streams on release.
REQ-036 SHALL cover: start pulsed again during RUN at word 3 -> ignored; exactly 8 beats and one done.
REQ-037 SHALL cover: rst_n low for 1 cycle at word 5 -> all outputs 0 immediately; a fresh start afterwards yields beats 0..21 from index 0.
REQ-038 SHALL cover: NUM_WORDS=1 -> a single beat with data 0 and m_tlast=1, then done.

Source files
------------

// File: rtl/gat_feat_streamer_pkg.sv
// Shared GAT definitions: dataset sizes, feature-readout defaults and the streamer state type.
package gat_feat_streamer_pkg;

    localparam int NUM_SUBGRAPHS   = 2708;
    localparam int NUM_FEATURE_OUT = 16;

    localparam int GAT_NUM_WORDS   = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
    localparam int GAT_RD_LAT      = 2;
    localparam int GAT_FIFO_DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } stream_state_e;

endpackage

// File: rtl/gat_feat_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; any DEPTH >= 2.
module gat_feat_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != CNT_W'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/gat_feat_streamer.sv
// Reads NUM_WORDS feature words from the GAT feature BRAM and streams them out with
// credit-based flow control so the skid FIFO can never overflow.
module gat_feat_streamer
    import gat_feat_streamer_pkg::*;
#(
    parameter  int TOP_WIDTH          = 32,
    parameter  int NEW_FEATURE_WIDTH  = 32,
    parameter  int NUM_WORDS          = GAT_NUM_WORDS,
    parameter  int RD_LAT             = GAT_RD_LAT,
    parameter  int FIFO_DEPTH         = GAT_FIFO_DEPTH,
    localparam int NEW_FEATURE_ADDR_W = $clog2(NUM_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [TOP_WIDTH-1:0]          m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast
);

    localparam int IDX_W   = (NEW_FEATURE_ADDR_W > 0) ? NEW_FEATURE_ADDR_W : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = NEW_FEATURE_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    stream_state_e    state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, vld_d, lst_q, lst_d;
    logic [CNT_W-1:0] fifo_count;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic             fifo_empty;
    logic             issue, pop;
    logic [IDX_W+1:0] addr_full;
    int               inflight;

    // A read may only be issued when its eventual FIFO slot is already guaranteed.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (vld_q[i]) inflight = inflight + 1;
        end
        issue = (state_q == ST_RUN) && ((int'(fifo_count) + inflight) < FIFO_DEPTH);
        pop   = m_tvalid && m_tready;

        vld_d[0] = issue;
        lst_d[0] = issue && (rd_idx_q == LAST_IDX);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        addr_d   = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    rd_idx_d = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = rd_idx_q;
                    if (rd_idx_q == LAST_IDX) state_d = ST_DRAIN;
                    else rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                if (pop && m_tlast && (inflight == 0) && (fifo_count == CNT_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_idx_q <= '0;
            addr_q   <= '0;
            vld_q    <= '0;
            lst_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            addr_q   <= addr_d;
            vld_q    <= vld_d;
            lst_q    <= lst_d;
        end
    end

    gat_feat_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (vld_q[RD_LAT-1]),
        .wdata_i ({lst_q[RD_LAT-1], feat_bram_dout}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The address bus shows the read being issued, otherwise the last one issued.
    assign addr_full       = {(issue ? rd_idx_q : addr_q), 2'b00};
    assign feat_bram_addrb = addr_full[NEW_FEATURE_ADDR_W+1:0];

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? TOP_WIDTH'(fifo_rdata[NEW_FEATURE_WIDTH-1:0]) : '0;
    assign m_tlast  = m_tvalid && fifo_rdata[NEW_FEATURE_WIDTH];
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_gat_feat_streamer.sv
// Scoreboard bench: an 8-word streamer and a 1-word streamer, each fed by a BRAM model
// returning index*3 after two cycles.
module tb_gat_feat_streamer;

    localparam int NW    = 8;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        startA, startB, treadyA, treadyB;
    logic        busyA, doneA, tvalidA, tlastA;
    logic        busyB, doneB, tvalidB, tlastB;
    logic [4:0]  addrA;
    logic [1:0]  addrB;
    logic [31:0] doutA, doutB, pipeA, pipeB, tdataA, tdataB;

    int checks = 0, passes = 0, cyc = 0;
    logic [32:0] expQA[$], expQB[$];
    int beatsA = 0, doneCntA = 0, startCycA = 0, lastAccA = 0, maxCntA = 0;
    int doneCntB = 0, startCycB = 0, lastAccB = 0;
    bit firstPendA = 0, firstPendB = 0;
    int readyMode = 0, phase = 0, base = 0;
    logic [3:0] togglePat = 4'b1001;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gat_feat_streamer #(.TOP_WIDTH(32), .NEW_FEATURE_WIDTH(32), .NUM_WORDS(NW),
                        .RD_LAT(2), .FIFO_DEPTH(DEPTH)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .busy(busyA), .done(doneA),
        .feat_bram_addrb(addrA), .feat_bram_dout(doutA), .m_tdata(tdataA),
        .m_tvalid(tvalidA), .m_tready(treadyA), .m_tlast(tlastA));

    gat_feat_streamer #(.TOP_WIDTH(32), .NEW_FEATURE_WIDTH(32), .NUM_WORDS(1),
                        .RD_LAT(2), .FIFO_DEPTH(DEPTH)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .busy(busyB), .done(doneB),
        .feat_bram_addrb(addrB), .feat_bram_dout(doutB), .m_tdata(tdataB),
        .m_tvalid(tvalidB), .m_tready(treadyB), .m_tlast(tlastB));

    always @(posedge clk) begin
        pipeA <= 32'(addrA >> 2) * 32'd3;
        doutA <= pipeA;
        pipeB <= 32'(addrB >> 2) * 32'd3;
        doutB <= pipeB;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor for the 8-word instance: compares every accepted or stalled beat against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (firstPendA && tvalidA) begin
                firstPendA = 0;
                checkOutput("A first valid latency", 64'(cyc - startCycA), 64'd4);
            end
            if (tvalidA && !treadyA && expQA.size() > 0)
                checkOutput("A stalled beat", {31'd0, tlastA, tdataA}, {31'd0, expQA[0]});
            if (tvalidA && treadyA) begin
                if (expQA.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL A unexpected beat: got 0x%0h, expected none", tdataA);
                end else begin
                    checkOutput("A beat", {31'd0, tlastA, tdataA}, {31'd0, expQA.pop_front()});
                end
                beatsA++;
                if (tlastA) lastAccA = cyc;
            end
            if (doneA) begin
                doneCntA++;
                checkOutput("A done after tlast", 64'(cyc - lastAccA), 64'd1);
            end
            if (int'(dutA.fifo_count) > maxCntA) maxCntA = int'(dutA.fifo_count);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (firstPendB && tvalidB) begin
                firstPendB = 0;
                checkOutput("B first valid latency", 64'(cyc - startCycB), 64'd4);
            end
            if (tvalidB && treadyB) begin
                if (expQB.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL B unexpected beat: got 0x%0h, expected none", tdataB);
                end else begin
                    checkOutput("B beat", {31'd0, tlastB, tdataB}, {31'd0, expQB.pop_front()});
                end
                lastAccB = cyc;
            end
            if (doneB) begin
                doneCntB++;
                checkOutput("B done after tlast", 64'(cyc - lastAccB), 64'd1);
            end
        end
    end

    initial begin
        treadyA = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            case (readyMode)
                0:       treadyA = 1'b1;
                1:       treadyA = togglePat[phase % 4];
                default: treadyA = 1'b0;
            endcase
        end
    end

    task automatic applyStimulus(input bit pushExp, input bit sync);
        if (pushExp) begin
            for (int i = 0; i < NW; i++) begin
                logic last;
                last = (i == NW - 1);
                expQA.push_back({last, 32'(i * 3)});
            end
        end
        if (sync) begin
            @(posedge clk);
            #1;
        end
        startA = 1'b1;
        if (pushExp) begin
            startCycA  = cyc;
            firstPendA = 1;
        end
        @(posedge clk);
        #1;
        startA = 1'b0;
    endtask

    task automatic waitDoneA(input int want, input int budget);
        int n = 0;
        while (doneCntA < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (doneCntA < want) begin
            checks++;
            $display("[TB] FAIL A done timeout: got %0d dones, expected %0d", doneCntA, want);
        end
    endtask

    task automatic waitBeatsA(input int want, input int budget);
        int n = 0;
        while (beatsA < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (beatsA < want) begin
            checks++;
            $display("[TB] FAIL A beat timeout: got %0d beats, expected %0d", beatsA, want);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b1; startA = 1'b0; startB = 1'b0; treadyB = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset A tvalid", 64'(tvalidA), 64'd0);
        checkOutput("reset A tlast", 64'(tlastA), 64'd0);
        checkOutput("reset A tdata", 64'(tdataA), 64'd0);
        checkOutput("reset A busy", 64'(busyA), 64'd0);
        checkOutput("reset A done", 64'(doneA), 64'd0);
        checkOutput("reset A addrb", 64'(addrA), 64'd0);
        checkOutput("reset B tvalid", 64'(tvalidB), 64'd0);
        checkOutput("reset B busy", 64'(busyB), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Full-rate readout with no backpressure.
        readyMode = 0;
        applyStimulus(1, 1);
        waitDoneA(1, 60);
        checkOutput("A stream span no bubbles", 64'(lastAccA - startCycA), 64'd11);
        checkOutput("A queue drained 1", 64'(expQA.size()), 64'd0);

        // Ready toggling 1,0,0,1.
        readyMode = 1;
        applyStimulus(1, 1);
        waitDoneA(2, 120);
        checkOutput("A queue drained 2", 64'(expQA.size()), 64'd0);

        // Long stall fills the FIFO to exactly its depth.
        readyMode = 2;
        applyStimulus(1, 1);
        repeat (50) @(negedge clk);
        checkOutput("A stall addrb", 64'(addrA), 64'h1C);
        checkOutput("A stall tvalid", 64'(tvalidA), 64'd1);
        checkOutput("A stall busy", 64'(busyA), 64'd1);
        checkOutput("A stall fifo count", 64'(dutA.fifo_count), 64'(DEPTH));
        readyMode = 0;
        waitDoneA(3, 60);
        checkOutput("A queue drained 3", 64'(expQA.size()), 64'd0);

        // Second start while running is ignored.
        base = beatsA;
        applyStimulus(1, 1);
        waitBeatsA(base + 3, 30);
        applyStimulus(0, 0);
        waitDoneA(4, 60);
        repeat (20) @(negedge clk);
        checkOutput("A ignored start done count", 64'(doneCntA), 64'd4);
        checkOutput("A ignored start beat count", 64'(beatsA - base), 64'd8);
        checkOutput("A ignored start busy", 64'(busyA), 64'd0);

        // Asynchronous reset mid-readout, then a restart on the first edge after release.
        base = beatsA;
        applyStimulus(1, 1);
        waitBeatsA(base + 5, 30);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset A tvalid", 64'(tvalidA), 64'd0);
        checkOutput("midreset A tlast", 64'(tlastA), 64'd0);
        checkOutput("midreset A tdata", 64'(tdataA), 64'd0);
        checkOutput("midreset A busy", 64'(busyA), 64'd0);
        checkOutput("midreset A addrb", 64'(addrA), 64'd0);
        expQA.delete();
        firstPendA = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1, 0);
        waitDoneA(5, 60);
        checkOutput("A queue drained 5", 64'(expQA.size()), 64'd0);

        // Single-word readout.
        expQB.push_back({1'b1, 32'd0});
        @(posedge clk);
        #1 startB = 1'b1;
        startCycB  = cyc;
        firstPendB = 1;
        @(posedge clk);
        #1 startB = 1'b0;
        begin
            int n = 0;
            while (doneCntB < 1 && n < 30) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("B done count", 64'(doneCntB), 64'd1);
        checkOutput("B queue drained", 64'(expQB.size()), 64'd0);
        @(negedge clk);
        checkOutput("B idle after done", 64'(busyB), 64'd0);

        checkOutput("A fifo count bound", 64'(maxCntA <= DEPTH), 64'd1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
